// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller and its sensor front end:
// debounce FSM state encoding and default timing values.
package traffic_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CHK_PRESS = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] CHK_REL   = 2'd3;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned HOLDOFF_CYCLES_DEF  = 64;

  localparam logic [7:0] PRESS_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset; shared by the
// sensor and reset_button input paths.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make s1_q -> s2_q a true two-stage shift.
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronises and debounces the side-street sensor pin and holds a sticky
// request until acknowledged. Define SENSOR_HOLDOFF_EN for post-ack lockout.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       req_ack,
  output logic       sensor_level,
  output logic       sensor_req,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must lie in 2..65535");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor_raw),
    .q_o   (s)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_evt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = CHK_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = CHK_REL;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_REL: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_DONE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic holdoff_clear;

`ifdef SENSOR_HOLDOFF_EN
  localparam int unsigned HO_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

  logic [HO_W-1:0] holdoff_q, holdoff_d;

  // Load on the edge where the ack actually clears the request.
  always_comb begin
    holdoff_d = holdoff_q;
    if (req_ack && sensor_req && !press_pulse) begin
      holdoff_d = HO_W'(HOLDOFF_CYCLES);
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) holdoff_q <= '0;
    else       holdoff_q <= holdoff_d;
  end

  assign holdoff_clear = (holdoff_q == '0);
`else
  assign holdoff_clear = 1'b1;
`endif

  // Output stage sits one register behind the FSM so press_pulse and
  // sensor_level move together on the edge after the state changes.
  logic       pulse_arm_q, pulse_arm_d;
  logic       level_q, level_d;
  logic       pulse_q, pulse_d;
  logic       req_q, req_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    pulse_arm_d = press_evt & holdoff_clear;
    level_d     = (state_q == PRESSED) || (state_q == CHK_REL);
    pulse_d     = pulse_arm_q;
    count_d     = (pulse_arm_q && count_q != PRESS_COUNT_MAX) ? count_q + 8'd1 : count_q;
    req_d       = pulse_q | (req_q & ~req_ack);
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here is a handful of flops, so all take the reset.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse_arm_q <= 1'b0;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
      req_q       <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_arm_q <= pulse_arm_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      req_q       <= req_d;
      count_q     <= count_d;
    end
  end

  assign sensor_level = level_q;
  assign sensor_req   = req_q;
  assign press_pulse  = pulse_q;
  assign press_count  = count_q;

endmodule
